systolic_feeder: RTL and testbench
==================================

# systolic_feeder

Edge driver for the SIZE×SIZE weight-stationary PE array. It accepts weight rows and activation vectors over valid/ready streams. It shifts weights down the columns using the shared weight-valid chain. It then injects activations into the rows with a diagonal skew and holds the array quiet long enough for every partial sum to drain out of the bottom row. It sits between the on-chip buffers and the array's top and left edges.

## Interface
- SIZE, 8, array dimension (rows = columns)
- CNT_W, $clog2(2*SIZE), width of the phase counter
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- Weight_row_in  in  8*SIZE  one weight row; byte c feeds column c
- Weight_row_valid  in  1  weight row offered
- Weight_row_ready  out  1  feeder accepts a weight row this cycle
- Act_vec_in  in  8*SIZE  one activation vector; byte r feeds array row r
- Act_vec_valid  in  1  vector offered
- Act_vec_last  in  1  qualifies Act_vec_valid; marks the final vector of a pass
- Act_vec_ready  out  1  feeder accepts a vector this cycle
- Weight_out  out  8*SIZE  to Weight_in of the top-row PEs
- Weight_out_valid  out  1  to Weight_in_valid of the top-row PEs; all columns share it
- Activation_out  out  8*SIZE  to Activation_in of the column-0 PEs, skewed
- Row_valid_out  out  SIZE  bit r marks a real, non-bubble activation on row r; skewed the same way as the data
- Busy  out  1  high in every state except IDLE
- Done  out  1  one-cycle pulse when the FLUSH phase completes

## Operation
- States and behaviour:
  - IDLE: Weight_row_ready = 1. Act_vec_ready = Weights_loaded.
  - LOAD_W: Weight_row_ready = 1. Act_vec_ready = 0.
  - STREAM: Weight_row_ready = 0. Act_vec_ready = 1.
  - FLUSH: both ready outputs are 0.
- Transitions:
  - IDLE → LOAD_W on a weight handshake. The counter is set to 1.
  - IDLE → STREAM on a vector handshake, and only if the Weights_loaded flag is set.
  - If both streams are valid in IDLE, the weight stream wins.
  - LOAD_W: each handshake increments the counter. When the SIZE-th row is accepted, go to STREAM and set Weights_loaded.
  - STREAM: a handshake with Act_vec_last = 1 clears the counter and moves to FLUSH.
  - FLUSH: lasts exactly 2*SIZE-1 cycles (SIZE-1 for the skew to drain, SIZE for psums to fall through the array). On exit, pulse Done and return to IDLE.
- Weight path:
  - Each accepted row is registered onto Weight_out with Weight_out_valid = 1 for one cycle.
  - Gaps between rows are allowed. In a gap cycle Weight_out_valid = 0.
  - The first row accepted lands in array row SIZE-1. The SIZE-th row lands in row 0. Upstream presents rows bottom-first.
- Activation path:
  - An accepted vector's byte r is delayed by r extra cycles. Row_valid_out[r] is delayed identically.
  - A non-handshake cycle in STREAM or FLUSH injects a zero byte with valid = 0 at the row-0 input. This is a bubble.
- Weight loading and streaming are mutually exclusive. While Weight_out_valid = 1, every skew stage must already hold zeros. The FSM guarantees this, because LOAD_W is entered only from IDLE, after FLUSH has drained the skew.
- Outputs are registered. Pixel data are never modified, only delayed.

## Timing
- Reset values: Weight_out = 0, Weight_out_valid = 0, Activation_out = 0, Row_valid_out = 0, Busy = 0, Done = 0, Weights_loaded = 0. State = IDLE.
- Reset mid-operation clears every skew stage and abandons the pass without a Done pulse.
- Weight handshake at edge t → Weight_out_valid is high in cycle t+1.
- Vector handshake at edge t → row r data and valid appear in cycle t+1+r.
- Last vector accepted at edge t → Done is high in cycle t+2*SIZE. The feeder enters IDLE with Busy = 0 in that same cycle.
- Throughput is 1 vector per cycle with no bubbles. Accepting back-to-back passes in IDLE costs 0 extra cycles beyond FLUSH.
- A single-vector pass (first vector has last = 1) goes STREAM → FLUSH after one cycle.

## Structure
- The shared package holds:
  - the state enum: IDLE, LOAD_W, STREAM, FLUSH
  - the function flush_len(SIZE) = 2*SIZE-1
  - the byte width constant DATA_W = 8
- Sub-module skew_delay_line (parameters DEPTH, WIDTH): a DEPTH-stage register chain with asynchronous reset that passes data through when DEPTH = 0. Instance r carries {valid, byte} with DEPTH = r.

## Test plan
- Weight load, SIZE=4: offer rows 0x04..,0x03..,0x02..,0x01.. back-to-back → Weight_out_valid high for exactly 4 consecutive cycles, then state is STREAM and Weights_loaded = 1.
- Skew: vector bytes {r3=0x40,r2=0x30,r1=0x20,r0=0x10} accepted at t → Activation_out row0 = 0x10 at t+1, row1 = 0x20 at t+2, row2 = 0x30 at t+3, row3 = 0x40 at t+4. Row_valid_out matches, and is 0 elsewhere.
- Bubbles: Act_vec_valid toggles 1,0,1 → the middle slot is zero with Row_valid_out = 0 on each row, at its skewed cycle.
- Flush/Done: last vector at t with SIZE=4 → Done is a single pulse at t+8. Act_vec_ready = 0 during cycles t+1..t+7.
- Reuse of loaded weights: after Done, a vector offered in IDLE with no weight row → accepted directly, and Weight_out_valid stays 0.
- Async reset asserted mid-STREAM, between clock edges → all outputs read 0 immediately. A following vector is not accepted until a new weight load completes.

Source files
------------

// File: rtl/systolic_feeder_pkg.sv
// Shared types and constants for the systolic array edge feeder.
package systolic_feeder_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_W = 2'd1,
    STREAM = 2'd2,
    FLUSH  = 2'd3
  } state_t;

  // Skew drain (SIZE-1) plus psum fall-through (SIZE).
  function automatic int flush_len(input int size);
    return 2 * size - 1;
  endfunction

endpackage

// File: rtl/systolic_feeder_if.sv
// Streams in from the on-chip buffers and edge signals out to the PE array.
interface systolic_feeder_if
  import systolic_feeder_pkg::*;
#(
  parameter int SIZE = 8
);

  logic [SIZE-1:0][DATA_W-1:0] i_weight_row;
  logic                        i_weight_row_valid;
  logic                        o_weight_row_ready;
  logic [SIZE-1:0][DATA_W-1:0] i_act_vec;
  logic                        i_act_vec_valid;
  logic                        i_act_vec_last;
  logic                        o_act_vec_ready;
  logic [SIZE-1:0][DATA_W-1:0] o_weight_out;
  logic                        o_weight_out_valid;
  logic [SIZE-1:0][DATA_W-1:0] o_activation_out;
  logic [SIZE-1:0]             o_row_valid_out;
  logic                        o_busy;
  logic                        o_done;
  logic                        o_weights_loaded;

  modport slave (
    input  i_weight_row, i_weight_row_valid, i_act_vec, i_act_vec_valid, i_act_vec_last,
    output o_weight_row_ready, o_act_vec_ready, o_weight_out, o_weight_out_valid,
           o_activation_out, o_row_valid_out, o_busy, o_done, o_weights_loaded
  );

  modport master (
    output i_weight_row, i_weight_row_valid, i_act_vec, i_act_vec_valid, i_act_vec_last,
    input  o_weight_row_ready, o_act_vec_ready, o_weight_out, o_weight_out_valid,
           o_activation_out, o_row_valid_out, o_busy, o_done, o_weights_loaded
  );

endinterface

// File: rtl/systolic_feeder_skew_delay_line.sv
// DEPTH-stage register chain; DEPTH = 0 is a straight wire.
module skew_delay_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  generate
    if (DEPTH == 0) begin : g_pass
      logic w_unused;
      assign w_unused = clk ^ rst;
      assign o_q      = i_d;
    end else begin : g_pipe
      logic [DEPTH-1:0][WIDTH-1:0] r_pipe;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_pipe <= '0;
        end else begin
          r_pipe[0] <= i_d;
          for (int i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
        end
      end
      assign o_q = r_pipe[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/systolic_feeder.sv
// Weight loader and diagonally skewed activation injector for a SIZE x SIZE
// weight-stationary array; holds the array quiet until all psums drain.
module systolic_feeder
  import systolic_feeder_pkg::*;
#(
  parameter int SIZE  = 8,
  parameter int CNT_W = $clog2(2 * SIZE)
) (
  input logic clk,
  input logic rst,
  systolic_feeder_if.slave bus
);

  localparam int FLUSH_LEN = flush_len(SIZE);

  state_t                      r_state, w_state_nxt;
  logic [CNT_W-1:0]            r_cnt, w_cnt_nxt;
  logic                        r_loaded, w_loaded_nxt;
  logic                        w_w_ready, w_a_ready;
  logic                        w_w_hs, w_a_hs;
  logic                        w_done_nxt;

  logic [SIZE-1:0][DATA_W-1:0] r_weight;
  logic                        r_weight_vld;
  logic [SIZE-1:0][DATA_W-1:0] r_inj_vec;
  logic                        r_inj_vld;
  logic                        r_done;
  logic [SIZE-1:0][DATA_W:0]   w_skew_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_loaded <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_loaded <= w_loaded_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_loaded_nxt = r_loaded;
    w_w_ready    = 1'b0;
    w_a_ready    = 1'b0;
    w_w_hs       = 1'b0;
    w_a_hs       = 1'b0;
    w_done_nxt   = 1'b0;
    case (r_state)
      IDLE: begin
        w_w_ready = 1'b1;
        w_a_ready = r_loaded;
        // A pending weight row always beats a pending vector.
        w_w_hs    = bus.i_weight_row_valid;
        w_a_hs    = bus.i_act_vec_valid && r_loaded && !bus.i_weight_row_valid;
        if (w_w_hs) begin
          w_state_nxt = LOAD_W;
          w_cnt_nxt   = CNT_W'(1);
        end else if (w_a_hs) begin
          w_state_nxt = bus.i_act_vec_last ? FLUSH : STREAM;
          w_cnt_nxt   = '0;
        end
      end
      LOAD_W: begin
        w_w_ready = 1'b1;
        w_w_hs    = bus.i_weight_row_valid;
        if (w_w_hs) begin
          if (r_cnt == CNT_W'(SIZE - 1)) begin
            w_state_nxt  = STREAM;
            w_loaded_nxt = 1'b1;
            w_cnt_nxt    = '0;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
      STREAM: begin
        w_a_ready = 1'b1;
        w_a_hs    = bus.i_act_vec_valid;
        if (w_a_hs && bus.i_act_vec_last) begin
          w_state_nxt = FLUSH;
          w_cnt_nxt   = '0;
        end
      end
      FLUSH: begin
        if (r_cnt == CNT_W'(FLUSH_LEN - 1)) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
          w_done_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Non-handshake cycles inject zero bubbles so the array never sees stale data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_weight     <= '0;
      r_weight_vld <= 1'b0;
      r_inj_vec    <= '0;
      r_inj_vld    <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_weight     <= w_w_hs ? bus.i_weight_row : '0;
      r_weight_vld <= w_w_hs;
      r_inj_vec    <= w_a_hs ? bus.i_act_vec : '0;
      r_inj_vld    <= w_a_hs;
      r_done       <= w_done_nxt;
    end
  end

  genvar r;
  generate
    for (r = 0; r < SIZE; r++) begin : g_row
      skew_delay_line #(
        .DEPTH (r),
        .WIDTH (DATA_W + 1)
      ) u_skew (
        .clk (clk),
        .rst (rst),
        .i_d ({r_inj_vld, r_inj_vec[r]}),
        .o_q (w_skew_q[r])
      );
      assign bus.o_activation_out[r] = w_skew_q[r][DATA_W-1:0];
      assign bus.o_row_valid_out[r]  = w_skew_q[r][DATA_W];
    end
  endgenerate

  assign bus.o_weight_row_ready = w_w_ready;
  assign bus.o_act_vec_ready    = w_a_ready;
  assign bus.o_weight_out       = r_weight;
  assign bus.o_weight_out_valid = r_weight_vld;
  assign bus.o_busy             = (r_state != IDLE);
  assign bus.o_done             = r_done;
  assign bus.o_weights_loaded   = r_loaded;

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed table, async-reset sequence and randomized run against a timestamp model.
module tb_systolic_feeder;

  localparam int S   = 4;
  localparam int NR  = 1500;
  localparam int NSB = NR + 2 * S + 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  systolic_feeder_if #(.SIZE(S)) bus ();

  systolic_feeder #(.SIZE(S)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input int cyc, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
    end
  endtask

  task automatic drive(input logic wv, input logic [31:0] wd, input logic av, input logic al,
                       input logic [31:0] ad);
    bus.i_weight_row_valid = wv;
    bus.i_weight_row       = wd;
    bus.i_act_vec_valid    = av;
    bus.i_act_vec_last     = al;
    bus.i_act_vec          = ad;
  endtask

  typedef struct {
    logic        wv;
    logic [31:0] wd;
    logic        av;
    logic        al;
    logic [31:0] ad;
    logic        e_wr;
    logic        e_ar;
    logic        e_busy;
    logic        e_wov;
    logic [31:0] e_wout;
    logic        e_done;
    logic [31:0] e_act;
    logic [3:0]  e_rv;
  } vec_t;

  vec_t tbl[17];

  logic [31:0] sb_act [NSB];
  logic [3:0]  sb_rv  [NSB];
  logic        sb_wov [NSB];
  logic [31:0] sb_w   [NSB];
  logic        sb_done[NSB];

  initial begin
    tbl[0]  = '{1, 32'h04040404, 0, 0, 0, 1, 0, 0, 0, 0,            0, 0,            4'h0};
    tbl[1]  = '{1, 32'h03030303, 0, 0, 0, 1, 0, 1, 1, 32'h04040404, 0, 0,            4'h0};
    tbl[2]  = '{1, 32'h02020202, 0, 0, 0, 1, 0, 1, 1, 32'h03030303, 0, 0,            4'h0};
    tbl[3]  = '{1, 32'h01010101, 0, 0, 0, 1, 0, 1, 1, 32'h02020202, 0, 0,            4'h0};
    tbl[4]  = '{0, 0, 1, 0, 32'h40302010,         0, 1, 1, 1, 32'h01010101, 0, 0,            4'h0};
    tbl[5]  = '{0, 0, 0, 0, 0,                    0, 1, 1, 0, 0,            0, 32'h00000010, 4'h1};
    tbl[6]  = '{0, 0, 1, 1, 32'h44332211,         0, 1, 1, 0, 0,            0, 32'h00002000, 4'h2};
    tbl[7]  = '{0, 0, 0, 0, 0,                    0, 0, 1, 0, 0,            0, 32'h00300011, 4'h5};
    tbl[8]  = '{0, 0, 0, 0, 0,                    0, 0, 1, 0, 0,            0, 32'h40002200, 4'ha};
    tbl[9]  = '{0, 0, 0, 0, 0,                    0, 0, 1, 0, 0,            0, 32'h00330000, 4'h4};
    tbl[10] = '{0, 0, 0, 0, 0,                    0, 0, 1, 0, 0,            0, 32'h44000000, 4'h8};
    tbl[11] = '{0, 0, 0, 0, 0,                    0, 0, 1, 0, 0,            0, 0,            4'h0};
    tbl[12] = '{0, 0, 0, 0, 0,                    0, 0, 1, 0, 0,            0, 0,            4'h0};
    tbl[13] = '{0, 0, 0, 0, 0,                    0, 0, 1, 0, 0,            0, 0,            4'h0};
    tbl[14] = '{0, 0, 0, 0, 0,                    1, 1, 0, 0, 0,            1, 0,            4'h0};
    tbl[15] = '{0, 0, 1, 1, 32'h88776655,         1, 1, 0, 0, 0,            0, 0,            4'h0};
    tbl[16] = '{0, 0, 0, 0, 0,                    0, 0, 1, 0, 0,            0, 32'h00000055, 4'h1};

    drive(0, 0, 0, 0, 0);
    #2;
    chk("rst_wov",  -1, 32'(bus.o_weight_out_valid), 0);
    chk("rst_wout", -1, bus.o_weight_out, 0);
    chk("rst_act",  -1, bus.o_activation_out, 0);
    chk("rst_rv",   -1, 32'(bus.o_row_valid_out), 0);
    chk("rst_busy", -1, 32'(bus.o_busy), 0);
    chk("rst_done", -1, 32'(bus.o_done), 0);
    chk("rst_ld",   -1, 32'(bus.o_weights_loaded), 0);
    @(negedge clk);
    rst = 1'b0;

    // Directed: load, skew, bubble, flush/Done, reuse of loaded weights.
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      chk("t_wready", i, 32'(bus.o_weight_row_ready), 32'(tbl[i].e_wr));
      chk("t_aready", i, 32'(bus.o_act_vec_ready), 32'(tbl[i].e_ar));
      chk("t_busy",   i, 32'(bus.o_busy), 32'(tbl[i].e_busy));
      chk("t_wov",    i, 32'(bus.o_weight_out_valid), 32'(tbl[i].e_wov));
      if (tbl[i].e_wov) chk("t_wout", i, bus.o_weight_out, tbl[i].e_wout);
      chk("t_done",   i, 32'(bus.o_done), 32'(tbl[i].e_done));
      chk("t_act",    i, bus.o_activation_out, tbl[i].e_act);
      chk("t_rv",     i, 32'(bus.o_row_valid_out), 32'(tbl[i].e_rv));
      if (i == 4) chk("t_loaded", i, 32'(bus.o_weights_loaded), 1);
      drive(tbl[i].wv, tbl[i].wd, tbl[i].av, tbl[i].al, tbl[i].ad);
    end

    // Async reset in the middle of a STREAM pass.
    @(negedge clk);
    drive(0, 0, 0, 0, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < S; i++) begin
      drive(1, 32'h0a0b0c0d + 32'(i), 0, 0, 0);
      @(negedge clk);
    end
    drive(0, 0, 1, 0, 32'h0d0c0b0a);
    @(negedge clk);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_wov",    0, 32'(bus.o_weight_out_valid), 0);
    chk("ar_act",    0, bus.o_activation_out, 0);
    chk("ar_rv",     0, 32'(bus.o_row_valid_out), 0);
    chk("ar_busy",   0, 32'(bus.o_busy), 0);
    chk("ar_done",   0, 32'(bus.o_done), 0);
    chk("ar_aready", 0, 32'(bus.o_act_vec_ready), 0);
    chk("ar_ld",     0, 32'(bus.o_weights_loaded), 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      chk("ar_noacc_ready", i, 32'(bus.o_act_vec_ready), 0);
      chk("ar_noacc_rv",    i, 32'(bus.o_row_valid_out), 0);
      chk("ar_noacc_busy",  i, 32'(bus.o_busy), 0);
    end
    drive(0, 0, 0, 0, 0);

    // Randomized run against a timestamp scoreboard.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < NSB; i++) begin
      sb_act[i] = '0; sb_rv[i] = '0; sb_wov[i] = 1'b0; sb_w[i] = '0; sb_done[i] = 1'b0;
    end
    begin
      bit m_loaded = 0, m_stream = 0;
      int m_rows = 0, m_done_cyc = -1;
      for (int c = 0; c < NR; c++) begin
        bit e_wr, e_ar, e_busy, wv, av, al, wh, ah;
        logic [31:0] wd, ad;
        @(negedge clk);
        if (c < m_done_cyc)  begin e_wr = 0; e_ar = 0;        e_busy = 1; end
        else if (m_rows > 0) begin e_wr = 1; e_ar = 0;        e_busy = 1; end
        else if (m_stream)   begin e_wr = 0; e_ar = 1;        e_busy = 1; end
        else                 begin e_wr = 1; e_ar = m_loaded; e_busy = 0; end
        chk("r_wready", c, 32'(bus.o_weight_row_ready), 32'(e_wr));
        chk("r_aready", c, 32'(bus.o_act_vec_ready), 32'(e_ar));
        chk("r_busy",   c, 32'(bus.o_busy), 32'(e_busy));
        chk("r_ld",     c, 32'(bus.o_weights_loaded), 32'(m_loaded));
        chk("r_wov",    c, 32'(bus.o_weight_out_valid), 32'(sb_wov[c]));
        if (sb_wov[c]) chk("r_wout", c, bus.o_weight_out, sb_w[c]);
        chk("r_done",   c, 32'(bus.o_done), 32'(sb_done[c]));
        chk("r_act",    c, bus.o_activation_out, sb_act[c]);
        chk("r_rv",     c, 32'(bus.o_row_valid_out), 32'(sb_rv[c]));
        wv = ($urandom_range(0, 9) < 3);
        av = ($urandom_range(0, 9) < 7);
        al = ($urandom_range(0, 9) == 0);
        wd = $urandom();
        ad = $urandom();
        drive(wv, wd, av, al, ad);
        wh = wv && e_wr;
        ah = av && e_ar && !wh;
        if (wh) begin
          sb_wov[c+1] = 1'b1;
          sb_w[c+1]   = wd;
          m_rows++;
          if (m_rows == S) begin
            m_rows = 0; m_loaded = 1; m_stream = 1;
          end
        end
        if (ah) begin
          for (int r = 0; r < S; r++) begin
            sb_act[c+1+r][8*r +: 8] = ad[8*r +: 8];
            sb_rv[c+1+r][r]         = 1'b1;
          end
          if (al) begin
            m_stream   = 0;
            m_done_cyc = c + 2 * S;
            sb_done[c+2*S] = 1'b1;
          end else begin
            m_stream = 1;
          end
        end
      end
    end
    drive(0, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
